// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad entry path: key codes, ALU op
// encoding, entry FSM states and the operand width.
package calc_pkg;

   localparam int W = 20;

   localparam logic [3:0] KEY_ADD = 4'd10;
   localparam logic [3:0] KEY_SUB = 4'd11;
   localparam logic [3:0] KEY_MUL = 4'd12;
   localparam logic [3:0] KEY_DIV = 4'd13;
   localparam logic [3:0] KEY_EQ  = 4'd14;
   localparam logic [3:0] KEY_CLR = 4'd15;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } alu_op_t;

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      OP_WAIT = 3'd1,
      ENTER_B = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4,
      ERR     = 3'd5
   } state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k < 4'd10;
   endfunction

   function automatic logic is_op(input logic [3:0] k);
      return (k >= KEY_ADD) && (k <= KEY_DIV);
   endfunction

   function automatic alu_op_t key_to_op(input logic [3:0] k);
      alu_op_t o;
      case (k)
         KEY_SUB: o = OP_SUB;
         KEY_MUL: o = OP_MUL;
         KEY_DIV: o = OP_DIV;
         default: o = OP_ADD;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/calc_entry_digit_accum.sv
// Decimal digit accumulator: acc*10 + digit with a flag when the result no
// longer fits in W bits.
module digit_accum
   import calc_pkg::*;
(
   input  logic [W-1:0] acc,
   input  logic [3:0]   digit,
   output logic [W-1:0] acc_next,
   output logic         ovf
);

   logic [W+3:0] wide;

   // Four guard bits hold the worst case (2^W-1)*10 + 9 without wrapping.
   always_comb begin
      wide     = {4'b0000, acc} * (W+4)'(10) + {{W{1'b0}}, digit};
      acc_next = wide[W-1:0];
      ovf      = |wide[W+3:W];
   end

endmodule

// File: rtl/calc_entry.sv
// Keypad entry sequencer: builds operands A/B and an operator from key events,
// strobes the external combinational ALU and holds the result for display.
module calc_entry
   import calc_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   input  logic [3:0]   key_code,
   output logic         key_ready,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_op,
   output logic         alu_go,
   input  logic [W-1:0] alu_res,
   output logic [W-1:0] disp_val,
   output logic         entry_ovf,
   output logic         err
);

   state_t       state, state_nxt;
   logic [W-1:0] a, b, result;
   alu_op_t      op, pend_op;
   logic         pend;
   logic         accept, k_digit, k_op, k_eq, k_clr, div0;
   logic [W-1:0] acc_sel, acc_next;
   logic         acc_ovf;

   assign accept  = key_valid & key_ready;
   assign k_digit = is_digit(key_code);
   assign k_op    = is_op(key_code);
   assign k_eq    = (key_code == KEY_EQ);
   assign k_clr   = (key_code == KEY_CLR);
   assign div0    = (op == OP_DIV) && (b == '0);
   assign acc_sel = (state == ENTER_B) ? b : a;

   digit_accum u_accum (
      .acc      (acc_sel),
      .digit    (key_code),
      .acc_next (acc_next),
      .ovf      (acc_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ENTER_A;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == EXEC) begin
         state_nxt = pend ? OP_WAIT : SHOW;
      end else if (accept && k_clr) begin
         state_nxt = ENTER_A;
      end else if (accept) begin
         case (state)
            ENTER_A: if (k_op) state_nxt = OP_WAIT;
            OP_WAIT: if (k_digit) state_nxt = ENTER_B;
            ENTER_B: if (k_eq || k_op) state_nxt = div0 ? ERR : EXEC;
            SHOW: begin
               if (k_op)         state_nxt = OP_WAIT;
               else if (k_digit) state_nxt = ENTER_A;
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      key_ready = (state != EXEC);
      alu_go    = (state == EXEC);
      err       = (state == ERR);
      case (state)
         ENTER_A, OP_WAIT: disp_val = a;
         ENTER_B, EXEC:    disp_val = b;
         SHOW:             disp_val = result;
         default:          disp_val = '0;
      endcase
   end

   // Operand/op registers feed the ALU directly, so they cannot change while
   // EXEC holds key_ready low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a         <= '0;
         b         <= '0;
         result    <= '0;
         op        <= OP_ADD;
         pend_op   <= OP_ADD;
         pend      <= 1'b0;
         entry_ovf <= 1'b0;
      end else if (state == EXEC) begin
         if (pend) begin
            a    <= alu_res;
            op   <= pend_op;
            pend <= 1'b0;
         end else begin
            result <= alu_res;
         end
      end else if (accept && k_clr) begin
         a         <= '0;
         b         <= '0;
         op        <= OP_ADD;
         pend      <= 1'b0;
         entry_ovf <= 1'b0;
      end else if (accept) begin
         case (state)
            ENTER_A: begin
               if (k_digit) begin
                  if (acc_ovf) entry_ovf <= 1'b1;
                  else         a <= acc_next;
               end else if (k_op) begin
                  op <= key_to_op(key_code);
               end
            end
            OP_WAIT: begin
               if (k_op)         op <= key_to_op(key_code);
               else if (k_digit) b  <= {{(W-4){1'b0}}, key_code};
            end
            ENTER_B: begin
               if (k_digit) begin
                  if (acc_ovf) entry_ovf <= 1'b1;
                  else         b <= acc_next;
               end else if (k_op) begin
                  pend    <= 1'b1;
                  pend_op <= key_to_op(key_code);
               end
            end
            SHOW: begin
               if (k_op) begin
                  a  <= result;
                  op <= key_to_op(key_code);
               end else if (k_digit) begin
                  a <= {{(W-4){1'b0}}, key_code};
                  b <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign alu_a  = a;
   assign alu_b  = b;
   assign alu_op = op;

endmodule

// File: tb/tb_calc_entry.sv
// Bench for calc_entry: drives key sequences, models the external ALU and
// scoreboards every ALU transaction plus display/status outputs.
module tb_calc_entry;
   import calc_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          key_valid = 1'b0;
   logic [3:0]    key_code = 4'd0;
   logic          key_ready;
   logic [W-1:0]  alu_a, alu_b, alu_res, disp_val;
   logic [1:0]    alu_op;
   logic          alu_go, entry_ovf, err;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
   } txn_t;

   txn_t sb[$];
   txn_t cur;
   int   n_chk = 0;
   int   n_fail = 0;
   int   go_cnt = 0;
   int   push_cnt = 0;

   calc_entry dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ready (key_ready),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_go    (alu_go),
      .alu_res   (alu_res),
      .disp_val  (disp_val),
      .entry_ovf (entry_ovf),
      .err       (err)
   );

   always #5 clk = ~clk;

   // External ALU
   logic [2*W-1:0] prod;
   always_comb begin
      prod = alu_a * alu_b;
      case (alu_op)
         2'b00:   alu_res = alu_a + alu_b;
         2'b01:   alu_res = alu_a - alu_b;
         2'b10:   alu_res = prod[W-1:0];
         default: alu_res = (alu_b == '0) ? '0 : alu_a / alu_b;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      txn_t t;
      t.a = a; t.b = b; t.op = op;
      sb.push_back(t);
      push_cnt++;
   endtask

   always @(negedge clk) begin
      if (rst_n && alu_go) begin
         go_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_go", 32'd1, 32'd0);
         end else begin
            cur = sb.pop_front();
            check("alu_a", 32'(alu_a), 32'(cur.a));
            check("alu_b", 32'(alu_b), 32'(cur.b));
            check("alu_op", 32'(alu_op), 32'(cur.op));
         end
      end
   end

   task automatic send_key(input logic [3:0] k);
      int n = 0;
      @(negedge clk);
      while (!key_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!key_ready) check("ready_timeout", 32'd0, 32'd1);
      key_valid = 1'b1;
      key_code  = k;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [3:0] ks[$]);
      foreach (ks[i]) send_key(ks[i]);
   endtask

   // EXEC occupies the cycle after the accepting edge; wait through it.
   task automatic through_exec();
      @(negedge clk);
      check("ready_in_exec", 32'(key_ready), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      check("rst_ready", 32'(key_ready), 32'd1);
      check("rst_go", 32'(alu_go), 32'd0);
      check("rst_disp", 32'(disp_val), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_ovf", 32'(entry_ovf), 32'd0);
      check("rst_alu", 32'({alu_a, alu_b, alu_op} != '0), 32'd0);
      #10 rst_n = 1'b1;

      // 12 + 34
      send_seq('{4'd1, 4'd2});
      check("disp_a12", 32'(disp_val), 32'd12);
      send_key(KEY_ADD);
      check("disp_opwait", 32'(disp_val), 32'd12);
      send_seq('{4'd3, 4'd4});
      check("disp_b34", 32'(disp_val), 32'd34);
      push_exp(20'd12, 20'd34, 2'b00);
      send_key(KEY_EQ);
      check("go_after_eq", 32'(alu_go), 32'd1);
      through_exec();
      check("disp_46", 32'(disp_val), 32'd46);
      check("ready_show", 32'(key_ready), 32'd1);

      // Entry overflow
      send_key(KEY_CLR);
      send_seq('{4'd1, 4'd0, 4'd4, 4'd8, 4'd5, 4'd7, 4'd5});
      check("disp_max", 32'(disp_val), 32'd1048575);
      check("ovf_before", 32'(entry_ovf), 32'd0);
      send_key(4'd9);
      check("disp_held", 32'(disp_val), 32'd1048575);
      check("ovf_set", 32'(entry_ovf), 32'd1);
      send_key(KEY_CLR);
      check("ovf_clr", 32'(entry_ovf), 32'd0);
      check("disp_clr", 32'(disp_val), 32'd0);

      // Divide by zero
      send_seq('{4'd9, KEY_DIV, 4'd0, KEY_EQ});
      check("err_set", 32'(err), 32'd1);
      check("err_disp", 32'(disp_val), 32'd0);
      send_seq('{4'd5, KEY_EQ, KEY_ADD});
      @(negedge clk);
      check("err_held", 32'(err), 32'd1);
      check("err_ready", 32'(key_ready), 32'd1);
      send_key(KEY_CLR);
      check("err_clr", 32'(err), 32'd0);
      check("err_clr_disp", 32'(disp_val), 32'd0);

      // Chained op from ENTER_B: 6*7 then -2
      push_exp(20'd6, 20'd7, 2'b10);
      send_seq('{4'd6, KEY_MUL, 4'd7, KEY_SUB});
      through_exec();
      check("chain_disp42", 32'(disp_val), 32'd42);
      push_exp(20'd42, 20'd2, 2'b01);
      send_seq('{4'd2, KEY_EQ});
      through_exec();
      check("chain_disp40", 32'(disp_val), 32'd40);

      // Op replacement, then wrapping subtraction starting from SHOW
      send_key(KEY_CLR);
      push_exp(20'd5, 20'd3, 2'b01);
      send_seq('{4'd5, KEY_ADD, KEY_SUB, 4'd3, KEY_EQ});
      through_exec();
      check("replace_disp2", 32'(disp_val), 32'd2);
      push_exp(20'd3, 20'd5, 2'b01);
      send_seq('{4'd3, KEY_SUB, 4'd5, KEY_EQ});
      through_exec();
      check("wrap_disp", 32'(disp_val), 32'd1048574);

      // Chaining from SHOW uses the last result as A
      push_exp(20'd1048574, 20'd1, 2'b00);
      send_seq('{KEY_ADD, 4'd1, KEY_EQ});
      through_exec();
      check("show_chain", 32'(disp_val), 32'd1048575);

      // Plain division
      send_key(KEY_CLR);
      push_exp(20'd8, 20'd2, 2'b11);
      send_seq('{4'd8, KEY_DIV, 4'd2, KEY_EQ});
      through_exec();
      check("div_disp4", 32'(disp_val), 32'd4);

      // Reset in the middle of EXEC
      send_key(KEY_CLR);
      send_seq('{4'd1, KEY_ADD, 4'd1, KEY_EQ});
      check("go_pre_rst", 32'(alu_go), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_exec_go", 32'(alu_go), 32'd0);
      check("rst_exec_ready", 32'(key_ready), 32'd1);
      check("rst_exec_disp", 32'(disp_val), 32'd0);
      check("rst_exec_alu", 32'({alu_a, alu_b, alu_op} != '0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(key_ready), 32'd1);
      check("post_rst_disp", 32'(disp_val), 32'd0);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("go_count", 32'(go_cnt), 32'(push_cnt));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
